// File: rtl/peripheral_noc_pkg.sv
// Shared constants for the APB4-to-NoC endpoint: register offsets and STATUS layout.
// No logic; consumed by the endpoint top.
// Holds the STATUS packing helper so field positions live in one place.
package peripheral_noc_pkg;

    // Register offsets as decoded from PADDR[3:2]
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // STATUS bit and field positions
    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_TX_CNT_LSB  = 4;
    localparam int ST_RX_CNT_LSB  = 8;
    localparam int ST_CNT_W       = 4;
    localparam int STATUS_W       = 12;

    // CTRL bit positions
    localparam int CTRL_RX_IRQ_EN = 0;

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic                tx_full,
        input logic                tx_empty,
        input logic                rx_full,
        input logic                rx_empty,
        input logic [ST_CNT_W-1:0] tx_cnt,
        input logic [ST_CNT_W-1:0] rx_cnt
    );
        logic [STATUS_W-1:0] s;
        s                                = '0;
        s[ST_TX_FULL]                    = tx_full;
        s[ST_TX_EMPTY]                   = tx_empty;
        s[ST_RX_FULL]                    = rx_full;
        s[ST_RX_EMPTY]                   = rx_empty;
        s[ST_TX_CNT_LSB +: ST_CNT_W]     = tx_cnt;
        s[ST_RX_CNT_LSB +: ST_CNT_W]     = rx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/peripheral_noc_fifo.sv
// Synchronous circular FIFO with occupancy count (DEPTH power of 2, >= 2).
// Latency: push visible at dat_o one cycle later; dat_o is the head, read combinationally.
// Backpressure: push ignored when full, pop ignored when empty, both judged on pre-edge state.
module peripheral_noc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers wrap naturally at DEPTH; count holds on simultaneous push+pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state; reset discards contents by emptying, storage left as is
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write, no reset needed
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= dat_i;
    end

endmodule

// File: rtl/peripheral_apb4_noc_endpoint.sv
// APB4 slave bridging register accesses to a valid/ready NoC flit port (TX and RX FIFOs).
// Latency: zero-wait APB; TXDATA write appears on out_flit next cycle; event_o lags RX state by one cycle.
// Backpressure: out_valid held until out_ready; in_ready drops when RX full; overflow/underflow flagged via PSLVERR.
module peripheral_apb4_noc_endpoint
    import peripheral_noc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [APB_DATA_WIDTH-1:0] out_flit,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic [APB_DATA_WIDTH-1:0] in_flit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      event_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      apb_wr, apb_rd;
    logic [1:0]                reg_off;
    logic                      tx_push, rx_pop;
    logic                      tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]             tx_count, rx_count;
    logic [APB_DATA_WIDTH-1:0] rx_head;
    logic                      ctrl_q, ctrl_d;
    logic                      event_q, event_d;
    logic                      unused_bits;

    assign apb_wr  = PSEL && PENABLE && PWRITE;
    assign apb_rd  = PSEL && PENABLE && !PWRITE;
    assign reg_off = PADDR[3:2];
    assign tx_push = apb_wr && (reg_off == OFF_TXDATA);
    assign rx_pop  = apb_rd && (reg_off == OFF_RXDATA);

    assign PREADY    = 1'b1;
    assign out_valid = !tx_empty;
    assign in_ready  = !rx_full;
    assign event_o   = event_q;

    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[APB_DATA_WIDTH-1:1]};

    peripheral_noc_fifo #(.WIDTH(APB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .push_i  (tx_push),
        .dat_i   (PWDATA),
        .pop_i   (out_ready),
        .dat_o   (out_flit),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    peripheral_noc_fifo #(.WIDTH(APB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .push_i  (in_valid),
        .dat_i   (in_flit),
        .pop_i   (rx_pop),
        .dat_o   (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Register decode: read mux and error flag, both zero outside an access phase
    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (PSEL && PENABLE) begin
            case (reg_off)
                OFF_TXDATA: PSLVERR = PWRITE ? tx_full : 1'b1;
                OFF_RXDATA: begin
                    if (PWRITE || rx_empty) PSLVERR = 1'b1;
                    else                    PRDATA  = rx_head;
                end
                OFF_STATUS: begin
                    if (PWRITE) PSLVERR = 1'b1;
                    else PRDATA = APB_DATA_WIDTH'(pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                                              ST_CNT_W'(tx_count), ST_CNT_W'(rx_count)));
                end
                OFF_CTRL: begin
                    if (!PWRITE) PRDATA = APB_DATA_WIDTH'(ctrl_q);
                end
            endcase
        end
    end

    // CTRL update and interrupt next-state
    always_comb begin
        ctrl_d  = ctrl_q;
        if (apb_wr && (reg_off == OFF_CTRL)) ctrl_d = PWDATA[CTRL_RX_IRQ_EN];
        event_d = ctrl_q && !rx_empty;
    end

    // CTRL and registered interrupt
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ctrl_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            event_q <= event_d;
        end
    end

endmodule

// File: tb/tb_peripheral_apb4_noc_endpoint.sv
module tb_peripheral_apb4_noc_endpoint;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        event_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    peripheral_apb4_noc_endpoint #(
        .APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .CLK(clk), .RSTN(rstn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready), .event_o(event_o)
    );

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #3 err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #3 d = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        n_tests++; if (event_o !== 1'b0) begin n_fail++; $display("FAIL rst_event: got %0b want 0", event_o); end
        n_tests++; if (pready !== 1'b1) begin n_fail++; $display("FAIL rst_pready: got %0b want 1", pready); end
        rstn = 1'b1;
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_000A || e !== 1'b0) begin n_fail++; $display("FAIL rst_status: got %h/%0b want 0000000a/0", d, e); end
        apb_read(8'h0C, d, e);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e;
        // setup phase of a read: outputs must stay quiet
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
        #3;
        n_tests++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin n_fail++; $display("FAIL setup_quiet: got %h/%0b want 0/0", prdata, pslverr); end
        @(posedge clk); #1 psel = 1'b0;
        apb_write(8'h08, 32'hFFFF_FFFF, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr_status_err: got %0b want 1", e); end
        apb_write(8'h04, 32'h1234_5678, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr_rxdata_err: got %0b want 1", e); end
        apb_read(8'h00, d, e);
        n_tests++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL rd_txdata_err: got %h/%0b want 0/1", d, e); end
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL err_noeffect_status: got %h want 0000000a", d); end
    endtask

    task automatic test_tx_single();
        logic e;
        out_ready = 1'b1;
        apb_write(8'h00, 32'hA5A5_0001, e);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL tx1_err: got %0b want 0", e); end
        n_tests++; if (out_valid !== 1'b1 || out_flit !== 32'hA5A5_0001) begin n_fail++; $display("FAIL tx1_flit: got %0b/%h want 1/a5a50001", out_valid, out_flit); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tx1_popped: got %0b want 0", out_valid); end
    endtask

    task automatic test_tx_full();
        logic [31:0] d; logic e;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apb_write(8'h00, 32'h100 + i, e);
            n_tests++; if (e !== (i == 4)) begin n_fail++; $display("FAIL txfull_err%0d: got %0b want %0b", i, e, (i == 4)); end
        end
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_0049) begin n_fail++; $display("FAIL txfull_status: got %h want 00000049", d); end
        n_tests++; if (out_valid !== 1'b1 || out_flit !== 32'h100) begin n_fail++; $display("FAIL txfull_stable: got %0b/%h want 1/100", out_valid, out_flit); end
    endtask

    task automatic test_full_pop_reject();
        // full TX, write coincides with an out_ready pop: write still rejected
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD;
        @(posedge clk); #1;
        penable = 1'b1; out_ready = 1'b1;
        #3;
        n_tests++; if (pslverr !== 1'b1) begin n_fail++; $display("FAIL fullpop_err: got %0b want 1", pslverr); end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; out_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_flit !== 32'h101 + i) begin n_fail++; $display("FAIL fullpop_drain%0d: got %0b/%h want 1/%h", i, out_valid, out_flit, 32'h101 + i); end
            @(posedge clk); #1;
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_rx_fill();
        logic [31:0] d; logic e;
        logic [31:0] fl;
        for (int i = 0; i < 5; i++) begin
            fl = 32'h11 * (i + 1);
            in_valid = 1'b1; in_flit = fl;
            #1;
            n_tests++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL rxfill_ready%0d: got %0b want %0b", i, in_ready, (i < 4)); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apb_read(8'h04, d, e);
            n_tests++; if (d !== 32'h11 * (i + 1) || e !== 1'b0) begin n_fail++; $display("FAIL rxfill_rd%0d: got %h/%0b want %h/0", i, d, e, 32'h11 * (i + 1)); end
        end
        apb_read(8'h04, d, e);
        n_tests++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL rxfill_underflow: got %h/%0b want 0/1", d, e); end
    endtask

    task automatic test_event();
        logic [31:0] d; logic e;
        apb_write(8'h0C, 32'hFFFF_FFFF, e);
        apb_read(8'h0C, d, e);
        n_tests++; if (d !== 32'h1 || e !== 1'b0) begin n_fail++; $display("FAIL ctrl_rd: got %h/%0b want 1/0", d, e); end
        n_tests++; if (event_o !== 1'b0) begin n_fail++; $display("FAIL evt_idle: got %0b want 0", event_o); end
        in_valid = 1'b1; in_flit = 32'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (event_o !== 1'b0) begin n_fail++; $display("FAIL evt_push_edge: got %0b want 0", event_o); end
        @(posedge clk); #1;
        n_tests++; if (event_o !== 1'b1) begin n_fail++; $display("FAIL evt_rise: got %0b want 1", event_o); end
        apb_read(8'h04, d, e);
        n_tests++; if (d !== 32'h77) begin n_fail++; $display("FAIL evt_rd: got %h want 77", d); end
        n_tests++; if (event_o !== 1'b1) begin n_fail++; $display("FAIL evt_pop_edge: got %0b want 1", event_o); end
        @(posedge clk); #1;
        n_tests++; if (event_o !== 1'b0) begin n_fail++; $display("FAIL evt_fall: got %0b want 0", event_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = 32'hA1 + i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(posedge clk); #1;
        penable = 1'b1; in_valid = 1'b1; in_flit = 32'hA4;
        #3;
        n_tests++; if (prdata !== 32'hA1 || pslverr !== 1'b0) begin n_fail++; $display("FAIL b2b_head: got %h/%0b want a1/0", prdata, pslverr); end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; in_valid = 1'b0;
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_0302) begin n_fail++; $display("FAIL b2b_status: got %h want 00000302", d); end
        for (int i = 0; i < 3; i++) begin
            apb_read(8'h04, d, e);
            n_tests++; if (d !== 32'hA2 + i || e !== 1'b0) begin n_fail++; $display("FAIL b2b_rd%0d: got %h/%0b want %h/0", i, d, e, 32'hA2 + i); end
        end
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL b2b_empty: got %h want 0000000a", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        out_ready = 1'b0;
        apb_write(8'h00, 32'h200, e);
        apb_write(8'h00, 32'h201, e);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_flit = 32'hB1 + i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_0220) begin n_fail++; $display("FAIL rmid_status_pre: got %h want 00000220", d); end
        n_tests++; if (out_valid !== 1'b1 || event_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %0b/%0b want 1/1", out_valid, event_o); end
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || event_o !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got %0b/%0b/%0b want 0/1/0", out_valid, in_ready, event_o); end
        @(posedge clk); #1;
        rstn = 1'b1;
        apb_read(8'h08, d, e);
        n_tests++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL rmid_status_post: got %h want 0000000a", d); end
        apb_read(8'h0C, d, e);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_ctrl: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_tx_single();
        test_tx_full();
        test_full_pop_reject();
        test_rx_fill();
        test_event();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
